unpool_layer: RTL and testbench
===============================

UNPOOL_LAYER -- requirements
Module: unpool_layer

Interface
REQ-001 SHALL have parameter FM_WIDTH, default 6, output feature-map width (even).
REQ-002 SHALL have parameter FM_HEIGHT, default 6, output feature-map height (even).
REQ-003 SHALL have parameter DATA_W, default 32, signed pixel width.
REQ-004 SHALL have parameter ZERO_FILL, default 0; 0 = nearest-neighbour replicate, 1 = value at top-left of 2x2, zeros elsewhere.
REQ-005 SHALL have ports, one clock; reset asynchronous, active-high:
 clk  input  1  clock, rising edge
 rst  input  1  async active-high reset
 start  input  1  begin one frame
 input_fm  input  DATA_W*(FM_WIDTH/2)*(FM_HEIGHT/2)  pooled map; element i at bits [i*DATA_W +: DATA_W], raster order
 busy  output  1  frame in progress
 out_valid  output  1  out_data/out_addr valid
 out_ready  input  1  consumer accepts
 out_data  output  DATA_W  signed unpooled pixel
 out_addr  output  6  raster index row*FM_WIDTH+col
 done  output  1  one-cycle frame-complete pulse

Function
REQ-006 SHALL implement states IDLE, EMIT, DONE.
REQ-007 IDLE: start=1 at an edge SHALL capture all of input_fm into an internal buffer, clear row/col to 0, enter EMIT.
REQ-008 input_fm SHALL be sampled only at that capture edge; later changes SHALL not affect the frame.
REQ-009 out_valid SHALL be 1 exactly while in EMIT; first valid pixel appears the cycle after start is sampled (latency 1).
REQ-010 Transfer SHALL occur on an edge with out_valid=1 and out_ready=1; each transfer advances col, wrapping to 0 and incrementing row at col=FM_WIDTH-1.
REQ-011 With out_valid=1 and out_ready=0, out_data and out_addr SHALL hold stable.
REQ-012 out_data SHALL equal buffer[(row>>1)*(FM_WIDTH/2)+(col>>1)]; if ZERO_FILL=1 and (row[0] or col[0]) is 1, out_data SHALL be 0.
REQ-013 out_data SHALL pass values bit-exact, sign preserved, no scaling.
REQ-014 Transfer of address FM_WIDTH*FM_HEIGHT-1 SHALL enter DONE; done=1 for exactly that one cycle, then IDLE.
REQ-015 start while in EMIT or DONE SHALL be ignored (no restart, no re-capture).
REQ-016 start held high continuously SHALL re-arm only from IDLE, i.e. frames separated by at least one IDLE cycle.
REQ-017 busy SHALL be 1 in EMIT and DONE, 0 in IDLE.
REQ-018 With out_ready=1 throughout, a frame SHALL take FM_WIDTH*FM_HEIGHT EMIT cycles plus one DONE cycle.
REQ-019 out_addr SHALL be out_valid-qualified; its value outside EMIT is don't-care but SHALL never be X after reset.

Reset
REQ-020 rst=1 SHALL immediately (asynchronously) force IDLE, busy=0, out_valid=0, done=0, out_data=0, out_addr=0, row=col=0.
REQ-021 rst asserted mid-frame SHALL abandon the frame; no done pulse SHALL follow; a new start after release SHALL begin at address 0.
REQ-022 Buffer contents need not be cleared by reset.

Verification
REQ-023 input_fm elements 1..9, ZERO_FILL=0, out_ready=1, start 1 cycle -> addrs 0..35 in 36 consecutive cycles, data 1,1,2,2,3,3,1,1,2,2,3,3,4,4,5,5,6,6,...,9,9; done one cycle after addr 35.
REQ-024 Same input, out_ready toggling 1/0 each cycle -> identical 36-value sequence, data/addr stable during stall cycles, 72 EMIT cycles total.
REQ-025 ZERO_FILL=1, elements 1..9 -> addr 0=1, addr 1=0, addr 6=0, addr 7=0, addr 2=2, addr 35=0, addr 28=9.
REQ-026 Elements -5 (0xFFFFFFFB) and 0x7FFFFFFF -> same bit patterns at corresponding 2x2 positions.
REQ-027 rst pulse at addr 17 -> out_valid=0 immediately, no done; restart -> stream from addr 0 with newly captured data.
REQ-028 start re-pulsed at addr 10 with different input_fm -> ignored; original frame completes unchanged with single done.

Source files
------------

// File: rtl/unpool_layer.sv
// 2x upsampling of a captured pooled feature map, streamed out in raster order
// over a valid/ready handshake; ZERO_FILL selects replicate or top-left-only.
module unpool_layer #(
  parameter int FM_WIDTH  = 6,
  parameter int FM_HEIGHT = 6,
  parameter int DATA_W    = 32,
  parameter int ZERO_FILL = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic [DATA_W*(FM_WIDTH/2)*(FM_HEIGHT/2)-1:0]   input_fm,
  output logic                                            busy,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic signed [DATA_W-1:0]                        out_data,
  output logic [5:0]                                      out_addr,
  output logic                                            done
);

  // state  | meaning
  // IDLE   | waiting for start; buffer captured on the start edge
  // EMIT   | streaming pixels, one per accepted handshake
  // DONE   | single-cycle frame-complete pulse
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  localparam int N_IN  = (FM_WIDTH/2)*(FM_HEIGHT/2);
  localparam int COL_W = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
  localparam int ROW_W = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t r_state, w_next;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_buf [N_IN];
  logic              w_capture, w_xfer, w_last_col, w_last, w_fill;
  logic [IDX_W-1:0]  w_idx;

  assign w_capture  = (r_state == S_IDLE) && start;
  assign w_xfer     = (r_state == S_EMIT) && out_ready;
  assign w_last_col = (r_col == COL_W'(FM_WIDTH-1));
  assign w_last     = w_last_col && (r_row == ROW_W'(FM_HEIGHT-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_EMIT;
      S_EMIT:  if (w_xfer && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_capture) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_xfer) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Buffer is deliberately left out of reset; it is only read while in EMIT.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N_IN; i++) r_buf[i] <= input_fm[i*DATA_W +: DATA_W];
    end
  end

  assign w_idx  = IDX_W'(int'(r_row >> 1) * (FM_WIDTH/2) + int'(r_col >> 1));
  assign w_fill = (ZERO_FILL != 0) && (r_row[0] || r_col[0]);

  assign out_valid = (r_state == S_EMIT);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_addr  = 6'(int'(r_row) * FM_WIDTH + int'(r_col));
  assign out_data  = (!out_valid || w_fill) ? '0 : r_buf[w_idx];

endmodule

// File: tb/tb_unpool_layer.sv
// Self-checking bench: two DUTs (replicate and zero-fill) share stimulus and are
// compared against a row/col arithmetic reference of the 2x unpooling.
module tb_unpool_layer;
  localparam int W  = 6;
  localparam int H  = 6;
  localparam int DW = 32;
  localparam int NI = (W/2)*(H/2);
  localparam int NP = W*H;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [DW*NI-1:0] input_fm;
  logic busy0, valid0, done0, busy1, valid1, done1;
  logic signed [DW-1:0] data0, data1;
  logic [5:0] addr0, addr1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] fm_ref [NI];

  always #5 clk = ~clk;

  unpool_layer #(.FM_WIDTH(W), .FM_HEIGHT(H), .DATA_W(DW), .ZERO_FILL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .busy(busy0),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .out_addr(addr0), .done(done0));

  unpool_layer #(.FM_WIDTH(W), .FM_HEIGHT(H), .DATA_W(DW), .ZERO_FILL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .input_fm(input_fm), .busy(busy1),
    .out_valid(valid1), .out_ready(out_ready), .out_data(data1), .out_addr(addr1), .done(done1));

  function automatic logic [DW-1:0] model(input int a, input bit zf);
    int r, c;
    r = a / W;
    c = a % W;
    if (zf && ((r % 2) != 0 || (c % 2) != 0)) return '0;
    return fm_ref[(r/2)*(W/2) + c/2];
  endfunction

  task automatic set_fm(input int kind);
    for (int i = 0; i < NI; i++) begin
      case (kind)
        0:       fm_ref[i] = DW'(i + 1);
        1:       fm_ref[i] = (i % 2 == 0) ? 32'hFFFF_FFFB : 32'h7FFF_FFFF;
        default: fm_ref[i] = $urandom;
      endcase
      input_fm[i*DW +: DW] = fm_ref[i];
    end
  endtask

  task automatic scramble_input;
    for (int i = 0; i < NI; i++) input_fm[i*DW +: DW] = $urandom;
  endtask

  // mode 0: always ready, 1: ready toggles starting low, 2: random ready
  task automatic run_frame(input string name, input int mode, input int restart_at, input int rst_at);
    int k, emit, cyc, done_cnt, last_x, done_cyc;
    bit r, restarted, finished;
    k = 0; emit = 0; cyc = 0; done_cnt = 0; last_x = -1; done_cyc = -2;
    restarted = 0; finished = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_input();
    while (cyc < 400 && !finished) begin
      start = 1'b0;
      if (rst_at >= 0 && k == rst_at) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valid0, busy0, done0, addr0, data0} !== '0)
          $display("FAIL %s async_reset valid=%b busy=%b done=%b addr=%0d data=%0h required all zero",
                   name, valid0, busy0, done0, addr0, data0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          n_checks++;
          if (done0 !== 1'b0 || busy0 !== 1'b0)
            $display("FAIL %s post_reset_quiet done=%b busy=%b required 0/0", name, done0, busy0);
          else n_pass++;
        end
        return;
      end
      if (cyc == 0) begin
        n_checks++;
        if (valid0 !== 1'b1) $display("FAIL %s latency valid=%b required 1", name, valid0);
        else n_pass++;
      end
      if (valid0 === 1'b1) begin
        emit++;
        n_checks++;
        if (addr0 !== 6'(k) || addr1 !== 6'(k) || valid1 !== 1'b1)
          $display("FAIL %s addr got=%0d/%0d valid1=%b required %0d", name, addr0, addr1, valid1, k);
        else n_pass++;
        n_checks++;
        if (data0 !== model(k, 0))
          $display("FAIL %s data_rep addr=%0d got=%0h required %0h", name, k, data0, model(k, 0));
        else n_pass++;
        n_checks++;
        if (data1 !== model(k, 1))
          $display("FAIL %s data_zf addr=%0d got=%0h required %0h", name, k, data1, model(k, 1));
        else n_pass++;
        case (mode)
          0:       r = 1'b1;
          1:       r = (emit % 2 == 0);
          default: r = 1'($urandom % 2);
        endcase
        out_ready = r;
        if (r) begin
          last_x = cyc;
          k++;
        end
      end else begin
        out_ready = 1'($urandom % 2);
      end
      if (restart_at >= 0 && k == restart_at && !restarted) begin
        restarted = 1'b1;
        start = 1'b1;
        scramble_input();
      end
      n_checks++;
      if (busy0 !== (valid0 | done0))
        $display("FAIL %s busy got=%b required %b", name, busy0, valid0 | done0);
      else n_pass++;
      if (done0 === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        n_checks++;
        if (valid0 !== 1'b0) $display("FAIL %s valid_in_done got=%b required 0", name, valid0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy0, valid0, done0} !== 3'b000)
          $display("FAIL %s idle_after_done busy/valid/done=%b required 000", name, {busy0, valid0, done0});
        else n_pass++;
        finished = 1'b1;
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    n_checks++;
    if (!finished) $display("FAIL %s timeout cycles=%0d required done within 400", name, cyc);
    else n_pass++;
    n_checks++;
    if (k !== NP || done_cnt !== 1)
      $display("FAIL %s frame_count transfers=%0d dones=%0d required %0d/1", name, k, done_cnt, NP);
    else n_pass++;
    n_checks++;
    if (done_cyc !== last_x + 1)
      $display("FAIL %s done_timing done_cycle=%0d required %0d", name, done_cyc, last_x + 1);
    else n_pass++;
    if (mode < 2) begin
      n_checks++;
      if (emit !== ((mode == 0) ? NP : 2*NP))
        $display("FAIL %s emit_cycles got=%0d required %0d", name, emit, (mode == 0) ? NP : 2*NP);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; input_fm = '0;
    @(negedge clk);
    n_checks++;
    if ({busy0, valid0, done0, addr0, data0, busy1, valid1, done1, addr1, data1} !== '0)
      $display("FAIL reset_state dut0 b/v/d=%b%b%b addr=%0d data=%0h dut1 addr=%0d data=%0h required zeros",
               busy0, valid0, done0, addr0, data0, addr1, data1);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy0, valid0, done0} !== 3'b000)
      $display("FAIL reset_release b/v/d=%b%b%b required 000", busy0, valid0, done0);
    else n_pass++;
  endtask

  task automatic test_basic;
    set_fm(0);
    run_frame("basic", 0, -1, -1);
  endtask

  task automatic test_stall;
    set_fm(0);
    run_frame("stall", 1, -1, -1);
  endtask

  task automatic test_signed;
    set_fm(1);
    run_frame("signed", 0, -1, -1);
  endtask

  task automatic test_reset_midframe;
    set_fm(2);
    run_frame("rst_mid", 0, -1, 17);
    set_fm(2);
    run_frame("rst_restart", 0, -1, -1);
  endtask

  task automatic test_restart_ignored;
    set_fm(0);
    run_frame("restart_ign", 0, 10, -1);
  endtask

  task automatic test_random;
    for (int f = 0; f < 4; f++) begin
      set_fm(2);
      run_frame("random", 2, -1, -1);
    end
  endtask

  task automatic test_start_held;
    int n;
    bit seen;
    set_fm(2);
    out_ready = 1'b1;
    start = 1'b1;
    n = 0; seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (done0 === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL start_held done_timeout cycles=%0d required done", n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL start_held idle_gap busy=%b required 0", busy0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (valid0 !== 1'b1 || addr0 !== 6'd0 || data0 !== model(0, 0))
      $display("FAIL start_held rearm valid=%b addr=%0d data=%0h required 1/0/%0h",
               valid0, addr0, data0, model(0, 0));
    else n_pass++;
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_signed();
    test_reset_midframe();
    test_restart_ignored();
    test_random();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
